// File: rtl/l1_pkg.sv
// Shared widths, tag-entry layout and controller state encoding for the L1 tag controller.
package l1_pkg;

    localparam int ADDR_W   = 32;
    localparam int INDEX_W  = 8;
    localparam int OFFSET_W = 6;
    localparam int TAG_W    = 18;

    // One SRAM word: valid bit above the stored tag.
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
    } tag_entry_t;

    typedef enum logic {
        ST_SWEEP = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/l1_tag_sweep.sv
// Sweep index counter: walks every set once and flags the final index.
module l1_tag_sweep
    import l1_pkg::*;
#(
    parameter int INDEX_W = l1_pkg::INDEX_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    output logic [INDEX_W-1:0] idx,
    output logic               done
);

    // Advance one set per enabled cycle; wrapping leaves the counter at 0 for the next sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
        end else if (en) begin
            idx <= idx + 1'b1;
        end
    end

    assign done = en && (idx == {INDEX_W{1'b1}});

endmodule

// File: rtl/l1_tag_ctrl.sv
// L1 tag controller: clears the tag SRAM after reset/flush, then serves
// pipelined lookups (two-cycle latency) alongside fill and invalidate writes.
module l1_tag_ctrl
    import l1_pkg::*;
#(
    parameter int ADDR_W   = l1_pkg::ADDR_W,
    parameter int INDEX_W  = l1_pkg::INDEX_W,
    parameter int OFFSET_W = l1_pkg::OFFSET_W,
    parameter int TAG_W    = l1_pkg::TAG_W
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               req_valid,
    input  logic [ADDR_W-1:0]  req_addr,
    output logic               req_ready,
    output logic               resp_valid,
    output logic               resp_hit,
    output logic [INDEX_W-1:0] resp_index,

    input  logic               fill_valid,
    input  logic [ADDR_W-1:0]  fill_addr,
    output logic               fill_ready,
    input  logic               inv_valid,
    input  logic [ADDR_W-1:0]  inv_addr,
    input  logic               flush_req,
    output logic               busy,
    output logic               flush_done,

    output logic               sram_csb0,
    output logic [INDEX_W-1:0] sram_addr0,
    output logic [TAG_W:0]     sram_din0,
    output logic               sram_csb1,
    output logic [INDEX_W-1:0] sram_addr1,
    input  logic [TAG_W:0]     sram_dout1
);

    state_t             state;
    logic               run;
    logic               sweep_done;
    logic [INDEX_W-1:0] sweep_idx;

    logic [INDEX_W-1:0] req_index;
    logic [INDEX_W-1:0] fill_index;
    logic [INDEX_W-1:0] inv_index;
    logic [TAG_W-1:0]   req_tag;
    logic [TAG_W-1:0]   fill_tag;

    logic               req_fire;
    logic               byp_p0;
    tag_entry_t         wr_entry;

    logic               vld_p1;
    logic [TAG_W-1:0]   tag_p1;
    logic [INDEX_W-1:0] idx_p1;
    logic               byp_p1;
    tag_entry_t         byp_word_p1;
    tag_entry_t         rd_entry_p1;
    logic               hit_p1;

    logic               vld_p2;
    logic               hit_p2;
    logic [INDEX_W-1:0] idx_p2;

    // Offset bits never select anything, and an invalidate only needs the set.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[OFFSET_W-1:0], fill_addr[OFFSET_W-1:0],
                                inv_addr[OFFSET_W-1:0], inv_addr[ADDR_W-1:OFFSET_W+INDEX_W]};

    assign req_index  = req_addr[OFFSET_W+INDEX_W-1:OFFSET_W];
    assign fill_index = fill_addr[OFFSET_W+INDEX_W-1:OFFSET_W];
    assign inv_index  = inv_addr[OFFSET_W+INDEX_W-1:OFFSET_W];
    assign req_tag    = req_addr[ADDR_W-1:ADDR_W-TAG_W];
    assign fill_tag   = fill_addr[ADDR_W-1:ADDR_W-TAG_W];

    assign run = (state == ST_RUN);

    l1_tag_sweep #(
        .INDEX_W (INDEX_W)
    ) u_sweep (
        .clk  (clk),
        .rst  (rst),
        .en   (!run),
        .idx  (sweep_idx),
        .done (sweep_done)
    );

    // Controller FSM: SWEEP clears every set, RUN serves traffic until a flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_SWEEP;
            busy       <= 1'b1;
            flush_done <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            case (state)
                ST_SWEEP: begin
                    if (sweep_done) begin
                        state      <= ST_RUN;
                        busy       <= 1'b0;
                        flush_done <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (flush_req) begin
                        state <= ST_SWEEP;
                        busy  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_SWEEP;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

    // A lookup arriving with a flush is refused so nothing new enters behind it.
    assign req_ready  = run && !flush_req;
    assign fill_ready = run && !inv_valid;
    assign req_fire   = req_valid && req_ready;

    // Write port: sweep clears, else invalidate beats fill; idle drives all-zero.
    always_comb begin
        sram_csb0  = 1'b1;
        sram_addr0 = '0;
        wr_entry   = '0;
        if (!run) begin
            sram_csb0  = 1'b0;
            sram_addr0 = sweep_idx;
        end else if (inv_valid) begin
            sram_csb0  = 1'b0;
            sram_addr0 = inv_index;
        end else if (fill_valid) begin
            sram_csb0      = 1'b0;
            sram_addr0     = fill_index;
            wr_entry.valid = 1'b1;
            wr_entry.tag   = fill_tag;
        end
    end

    assign sram_din0  = wr_entry;
    assign sram_csb1  = !req_fire;
    assign sram_addr1 = req_fire ? req_index : '0;

    // The SRAM returns the old word on a same-set collision, so keep the new one.
    assign byp_p0 = req_fire && !sram_csb0 && (sram_addr0 == req_index);

    // ---- stage p1: lookup issued to SRAM, word returns next cycle ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= req_fire;
        end
    end

    // Tag, set and any colliding write word follow the lookup into p1.
    always_ff @(posedge clk) begin
        tag_p1      <= req_tag;
        idx_p1      <= req_index;
        byp_p1      <= byp_p0;
        byp_word_p1 <= wr_entry;
    end

    assign rd_entry_p1 = byp_p1 ? byp_word_p1 : tag_entry_t'(sram_dout1);
    assign hit_p1      = rd_entry_p1.valid && (rd_entry_p1.tag == tag_p1);

    // ---- stage p2: registered compare result ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2 <= 1'b0;
        end else begin
            vld_p2 <= vld_p1;
        end
    end

    // Hit flag and set index carried beside vld_p2.
    always_ff @(posedge clk) begin
        hit_p2 <= hit_p1;
        idx_p2 <= idx_p1;
    end

    assign resp_valid = vld_p2;
    assign resp_hit   = vld_p2 && hit_p2;
    assign resp_index = vld_p2 ? idx_p2 : '0;

endmodule

// File: tb/tb_l1_tag_ctrl.sv
// Bench for l1_tag_ctrl: behavioural tag SRAM, cache-contents reference model,
// directed scenarios followed by randomized traffic.
module tb_l1_tag_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        resp_valid;
    logic        resp_hit;
    logic [7:0]  resp_index;
    logic        fill_valid;
    logic [31:0] fill_addr;
    logic        fill_ready;
    logic        inv_valid;
    logic [31:0] inv_addr;
    logic        flush_req;
    logic        busy;
    logic        flush_done;
    logic        sram_csb0;
    logic [7:0]  sram_addr0;
    logic [18:0] sram_din0;
    logic        sram_csb1;
    logic [7:0]  sram_addr1;
    logic [18:0] sram_dout1;

    l1_tag_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_hit   (resp_hit),
        .resp_index (resp_index),
        .fill_valid (fill_valid),
        .fill_addr  (fill_addr),
        .fill_ready (fill_ready),
        .inv_valid  (inv_valid),
        .inv_addr   (inv_addr),
        .flush_req  (flush_req),
        .busy       (busy),
        .flush_done (flush_done),
        .sram_csb0  (sram_csb0),
        .sram_addr0 (sram_addr0),
        .sram_din0  (sram_din0),
        .sram_csb1  (sram_csb1),
        .sram_addr1 (sram_addr1),
        .sram_dout1 (sram_dout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 1W1R macro: registered read, old data on a same-address collision.
    logic [18:0] sram_mem [256];
    initial begin
        for (int i = 0; i < 256; i++) sram_mem[i] <= 19'($urandom);
    end
    always @(posedge clk) begin
        if (!sram_csb0) sram_mem[sram_addr0] <= sram_din0;
        if (!sram_csb1) sram_dout1 <= sram_mem[sram_addr1];
    end

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: cache contents as plain arrays, responses as a timed queue.
    typedef struct {
        int       due;
        bit       hit;
        bit [7:0] idx;
    } exp_t;

    exp_t      exp_q[$];
    bit        mv[256];
    bit [17:0] mt[256];
    int        sweep_left = 256;
    bit        done_pend  = 0;
    int        cyc        = 0;

    logic        s_busy, s_flush_done, s_req_ready, s_fill_ready;
    logic        s_resp_valid, s_resp_hit, s_csb0;
    logic [7:0]  s_resp_index, s_addr0;
    logic [18:0] s_din0;

    function automatic logic [7:0] idx_of(input logic [31:0] a);
        return 8'((a >> 6) & 32'hFF);
    endfunction

    function automatic logic [17:0] tag_of(input logic [31:0] a);
        return 18'(a >> 14);
    endfunction

    function automatic logic [31:0] mk_addr(input logic [17:0] t, input logic [7:0] i,
                                            input logic [5:0] o);
        return (32'(t) << 14) | (32'(i) << 6) | 32'(o);
    endfunction

    // One clock: check the cycle at the falling edge against the model, then advance.
    task automatic tick();
        bit          we;
        logic [7:0]  wa;
        logic [18:0] wd;
        bit          ready_e;
        logic [7:0]  ri;
        exp_t        e;
        @(negedge clk);
        cyc++;
        s_busy       = busy;
        s_flush_done = flush_done;
        s_req_ready  = req_ready;
        s_fill_ready = fill_ready;
        s_resp_valid = resp_valid;
        s_resp_hit   = resp_hit;
        s_resp_index = resp_index;
        s_csb0       = sram_csb0;
        s_addr0      = sram_addr0;
        s_din0       = sram_din0;
        if (rst) begin
            exp_q.delete();
            sweep_left = 256;
            done_pend  = 0;
        end else begin
            check_eq("busy", 32'(busy), 32'(sweep_left > 0));
            check_eq("flush_done", 32'(flush_done), 32'(done_pend));
            ready_e = (sweep_left == 0) && !flush_req;
            check_eq("req_ready", 32'(req_ready), 32'(ready_e));
            check_eq("fill_ready", 32'(fill_ready), 32'((sweep_left == 0) && !inv_valid));
            we = 1; wa = '0; wd = '0;
            if (sweep_left > 0)  wa = 8'(256 - sweep_left);
            else if (inv_valid)  wa = idx_of(inv_addr);
            else if (fill_valid) begin wa = idx_of(fill_addr); wd = {1'b1, tag_of(fill_addr)}; end
            else we = 0;
            check_eq("wr_csb", 32'(sram_csb0), 32'(!we));
            check_eq("wr_addr", 32'(sram_addr0), 32'(wa));
            check_eq("wr_data", 32'(sram_din0), 32'(wd));
            if (we) begin
                mv[wa] = wd[18];
                mt[wa] = wd[17:0];
            end
            if (req_valid && ready_e) begin
                ri = idx_of(req_addr);
                check_eq("rd_csb", 32'(sram_csb1), 32'(0));
                check_eq("rd_addr", 32'(sram_addr1), 32'(ri));
                e.due = cyc + 2;
                e.hit = mv[ri] && (mt[ri] == tag_of(req_addr));
                e.idx = ri;
                exp_q.push_back(e);
            end else begin
                check_eq("rd_csb_idle", 32'(sram_csb1), 32'(1));
                check_eq("rd_addr_idle", 32'(sram_addr1), 32'(0));
            end
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e = exp_q.pop_front();
                check_eq("resp_valid", 32'(resp_valid), 32'(1));
                check_eq("resp_hit", 32'(resp_hit), 32'(e.hit));
                check_eq("resp_index", 32'(resp_index), 32'(e.idx));
            end else begin
                check_eq("resp_valid_idle", 32'(resp_valid), 32'(0));
                check_eq("resp_hit_idle", 32'(resp_hit), 32'(0));
                check_eq("resp_index_idle", 32'(resp_index), 32'(0));
            end
            done_pend = 0;
            if (sweep_left > 0) begin
                sweep_left--;
                if (sweep_left == 0) done_pend = 1;
            end else if (flush_req) begin
                sweep_left = 256;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = 0; fill_valid = 0; inv_valid = 0; flush_req = 0;
        req_addr = '0; fill_addr = '0; inv_addr = '0;
    endtask

    // Issue one lookup with nothing else in flight and check its response two cycles later.
    task automatic do_lookup(input string tag, input logic [31:0] a,
                             input logic exp_hit, input logic [7:0] exp_idx);
        req_valid = 1; req_addr = a;
        tick();
        req_valid = 0;
        tick();
        check_eq({tag, "_early"}, 32'(s_resp_valid), 32'(0));
        tick();
        check_eq({tag, "_valid"}, 32'(s_resp_valid), 32'(1));
        check_eq({tag, "_hit"}, 32'(s_resp_hit), 32'(exp_hit));
        check_eq({tag, "_index"}, 32'(s_resp_index), 32'(exp_idx));
    endtask

    // Count cycles from now until flush_done, bounded.
    task automatic wait_sweep(input string tag);
        int n;
        int busy_cnt;
        busy_cnt = 0;
        for (n = 0; n < 400; n++) begin
            tick();
            if (n == 0) begin
                check_eq({tag, "_first_busy"}, 32'(s_busy), 32'(1));
                check_eq({tag, "_first_ready"}, 32'(s_req_ready), 32'(0));
                check_eq({tag, "_first_fready"}, 32'(s_fill_ready), 32'(0));
                check_eq({tag, "_first_resp"}, 32'(s_resp_valid), 32'(0));
                check_eq({tag, "_first_fdone"}, 32'(s_flush_done), 32'(0));
                check_eq({tag, "_first_addr"}, 32'(s_addr0), 32'(0));
            end
            if (s_busy) busy_cnt++;
            if (s_flush_done) break;
        end
        check_eq({tag, "_len"}, 32'(n), 32'(256));
        check_eq({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(256));
        check_eq({tag, "_ready_after"}, 32'(s_req_ready), 32'(1));
    endtask

    initial begin
        logic [7:0]  idx_pool [4];
        logic [17:0] tag_pool [3];
        logic [31:0] ra;
        idx_pool = '{8'h8D, 8'h01, 8'h02, 8'hFF};
        tag_pool = '{18'd4, 18'd8, 18'h3FFFF};
        for (int i = 0; i < 256; i++) begin
            mv[i] = 1'($urandom);
            mt[i] = 18'($urandom);
        end

        idle_inputs();
        rst = 1;
        repeat (3) tick();
        rst = 0;
        wait_sweep("init_sweep");

        fill_valid = 1; fill_addr = 32'h0001_2340;
        tick();
        fill_valid = 0;
        do_lookup("hit_same_line", 32'h0001_2378, 1'b1, 8'h8D);
        do_lookup("miss_other_tag", 32'h0002_2340, 1'b0, 8'h8D);
        inv_valid = 1; inv_addr = 32'h0001_2340;
        tick();
        inv_valid = 0;
        do_lookup("miss_after_inv", 32'h0001_2340, 1'b0, 8'h8D);

        fill_valid = 1; fill_addr = 32'h0000_4040;
        req_valid  = 1; req_addr  = 32'h0000_4040;
        tick();
        idle_inputs();
        tick();
        tick();
        check_eq("bypass_valid", 32'(s_resp_valid), 32'(1));
        check_eq("bypass_hit", 32'(s_resp_hit), 32'(1));
        check_eq("bypass_index", 32'(s_resp_index), 32'(8'h01));

        inv_valid  = 1; inv_addr  = 32'h0000_4040;
        fill_valid = 1; fill_addr = 32'h0001_2340;
        tick();
        idle_inputs();
        check_eq("prio_fill_ready", 32'(s_fill_ready), 32'(0));
        check_eq("prio_csb0", 32'(s_csb0), 32'(0));
        check_eq("prio_addr0", 32'(s_addr0), 32'(8'h01));
        check_eq("prio_din0", 32'(s_din0), 32'(0));
        do_lookup("prio_no_fill", 32'h0001_2340, 1'b0, 8'h8D);
        do_lookup("prio_inv_done", 32'h0000_4040, 1'b0, 8'h01);

        fill_valid = 1; fill_addr = 32'h0000_4040;
        tick();
        fill_valid = 0;
        req_valid = 1; req_addr = 32'h0000_4040;
        tick();
        flush_req = 1;
        tick();
        check_eq("flush_blocks_req", 32'(s_req_ready), 32'(0));
        idle_inputs();
        tick();
        check_eq("inflight_valid", 32'(s_resp_valid), 32'(1));
        check_eq("inflight_hit", 32'(s_resp_hit), 32'(1));
        check_eq("flush_busy", 32'(s_busy), 32'(1));
        for (int i = 1; i < 100; i++) begin
            flush_req = (i == 40);
            req_valid = (i == 41);
            req_addr  = 32'h0000_4040;
            tick();
        end
        idle_inputs();
        check_eq("sweep_idx99", 32'(s_addr0), 32'(99));
        rst = 1;
        tick();
        rst = 0;
        wait_sweep("rst_sweep");

        for (int c = 0; c < 3000; c++) begin
            idle_inputs();
            if ($urandom_range(0, 1499) == 0) begin
                rst = 1;
            end else begin
                rst = 0;
                ra = mk_addr(tag_pool[$urandom_range(0, 2)], idx_pool[$urandom_range(0, 3)],
                             6'($urandom));
                req_valid = ($urandom_range(0, 9) < 6);
                req_addr  = ra;
                fill_valid = ($urandom_range(0, 9) < 2);
                fill_addr  = mk_addr(tag_pool[$urandom_range(0, 2)],
                                     idx_pool[$urandom_range(0, 3)], 6'($urandom));
                inv_valid = ($urandom_range(0, 9) == 0);
                inv_addr  = mk_addr(tag_pool[$urandom_range(0, 2)],
                                    idx_pool[$urandom_range(0, 3)], 6'($urandom));
                flush_req = ($urandom_range(0, 399) == 0);
            end
            tick();
        end
        rst = 0;
        idle_inputs();
        repeat (4) tick();
        check_eq("drain_queue_empty", 32'(exp_q.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/l1_tag_ctrl.md
L1_TAG_CTRL -- requirements
Module: l1_tag_ctrl

Interface
REQ-001 Parameters (name, default, meaning):
- ADDR_W, 32, byte address width.
- INDEX_W, 8, set index width (256 sets).
- OFFSET_W, 6, line offset width (64 B lines).
- TAG_W, 18, tag width; SRAM entry = {valid, tag} = 19 bits.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  sole clock; also drives both SRAM clock pins.
- rst  in  1  synchronous active-high reset.
REQ-003 Lookup ports:
- req_valid  in  1  lookup request.
- req_addr  in  ADDR_W  lookup byte address.
- req_ready  out  1  lookup accepted this cycle.
- resp_valid  out  1  lookup result valid (one-cycle pulse).
- resp_hit  out  1  stored entry is valid and its tag matches.
- resp_index  out  INDEX_W  set index of the result.
REQ-004 Update and maintenance ports:
- fill_valid  in  1  install tag; fill_addr  in  ADDR_W; fill_ready  out  1.
- inv_valid  in  1  invalidate set; inv_addr  in  ADDR_W.
- flush_req  in  1  pulse; invalidate all sets.
- busy  out  1  sweep in progress.
- flush_done  out  1  one-cycle pulse when a sweep ends.
REQ-005 SRAM ports (1W1R macro, active-low chip selects):
- sram_csb0  out  1; sram_addr0  out  INDEX_W; sram_din0  out  TAG_W+1.
- sram_csb1  out  1; sram_addr1  out  INDEX_W.
- sram_dout1  in  TAG_W+1.

Function
REQ-006 Address split: index = addr[OFFSET_W+INDEX_W-1:OFFSET_W]; tag = addr[ADDR_W-1:ADDR_W-TAG_W].
REQ-007 FSM states SWEEP and RUN; SWEEP->RUN after index 255 is written; RUN->SWEEP on flush_req.
REQ-008 SWEEP: write {0,0} to sweep index 0..255, one per cycle (256 cycles); busy=1; req_ready=0; fill_ready=0; inv_valid ignored.
REQ-009 In SWEEP, flush_done pulses in the cycle after the index-255 write.
REQ-010 RUN: req_ready=1. On req_valid, drive sram_csb1=0 and sram_addr1=index combinationally in the same cycle N.
REQ-011 Lookup accepted in cycle N: resp_valid=1 in cycle N+2 with resp_hit = dout[TAG_W] && dout[TAG_W-1:0]==tag(N). Lookup, tag and index are pipelined in registers; one lookup per cycle is sustained.
REQ-012 Write port: inv_valid has priority over fill_valid. In RUN, fill_ready = !inv_valid.
- Invalidate writes {0,0}.
- Fill writes {1,tag}.
- Both drive sram_csb0=0 in the same cycle.
REQ-013 Bypass: if a write is issued in the same cycle as a lookup to the same index, the comparison in N+1 uses the written word instead of sram_dout1.
REQ-014 A flush_req received while lookups are in flight:
- lookups accepted before the flush still respond;
- no new lookup is accepted until SWEEP ends.
REQ-015 flush_req during SWEEP is ignored.
REQ-016 When idle, sram_csb0 = sram_csb1 = 1; sram_addr and sram_din hold 0.

Reset
REQ-017 rst enters SWEEP at index 0 and drops all in-flight lookups. The next cycle shows:
- resp_valid=0, resp_hit=0, resp_index=0;
- flush_done=0, busy=1;
- req_ready=0, fill_ready=0.
REQ-018 rst asserted mid-sweep restarts the sweep at index 0.

Structure
REQ-019 Package l1_pkg holds ADDR_W, INDEX_W, OFFSET_W and TAG_W, the tag-entry struct {valid, tag} and the FSM state enum.
REQ-020 One sub-module, l1_tag_sweep: the index counter with a done flag. The SRAM macro is instantiated by the parent block, not here.

Verification
REQ-021 Release rst -> busy=1 for 256 cycles, 256 writes of 0 to addresses 0..255, flush_done pulses once, then req_ready=1.
REQ-022 Fill 0x0001_2340, then look up 0x0001_2378 -> resp_hit=1, resp_index=0x8D, exactly 2 cycles after acceptance.
REQ-023 Look up 0x0002_2340 (same set, different tag) -> resp_hit=0. Invalidate 0x0001_2340, then look up 0x0001_2340 -> resp_hit=0.
REQ-024 Fill 0x0000_4040 in the same cycle as a lookup of 0x0000_4040 -> resp_hit=1 (bypass).
REQ-025 Assert inv_valid and fill_valid together -> only the invalidate is written and fill_ready=0 that cycle.
REQ-026 Assert rst at sweep index 100 -> the sweep restarts at 0, and flush_done pulses 256 cycles after rst is released.
